// File: rtl/pi_row_fetcher.sv
// rtl/pi_row_fetcher.sv - steps a pi digit engine through one row of indices and writes the settled digits to a row buffer
module pi_row_fetcher #(
  parameter int              N         = 17,
  parameter int              COLS      = 80,
  parameter int              SETTLE    = 16,
  parameter longint unsigned MAX_INDEX = (64'd1 << N) - 64'd1,
  localparam int             AW        = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  base_index,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  pi_index,
  input  logic [3:0]    pi_digit,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [3:0]    wr_data
);

  localparam int            SW      = $clog2(SETTLE);
  localparam logic [SW-1:0] SC_LAST = SW'(SETTLE - 1);
  localparam logic [AW-1:0] COL_LAST = AW'(COLS - 1);
  localparam logic [N:0]    MAX_I   = MAX_INDEX[N:0];

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t        state;
  logic [SW-1:0] sc;
  logic [AW-1:0] col;
  logic          out_of_range;

  // Indices at or beyond MAX_INDEX have no stored digit and are written as 4'hF at once.
  assign out_of_range = ({1'b0, pi_index} >= MAX_I);
  assign busy         = (state == ISSUE);

  // Fetch sequencer: hold each index SETTLE cycles, then write the sampled digit and advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sc       <= '0;
      col      <= '0;
      pi_index <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state    <= ISSUE;
            pi_index <= base_index;
            sc       <= '0;
            col      <= '0;
          end
        end
        ISSUE: begin
          if (abort) begin
            state <= IDLE;
          end else if (out_of_range || sc == SC_LAST) begin
            wr_en    <= 1'b1;
            wr_addr  <= col;
            wr_data  <= out_of_range ? 4'hF : pi_digit;
            pi_index <= pi_index + 1'b1;
            col      <= col + 1'b1;
            sc       <= '0;
            if (col == COL_LAST) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            sc <= sc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pi_row_fetcher.md
PI_ROW_FETCHER -- requirements
Module: pi_row_fetcher

Interface
REQ-001 Parameter N, default 17: width of pi digit index.
REQ-002 Parameter COLS, default 80: digits fetched per row request; range 1..1024.
REQ-003 Parameter SETTLE, default 16: cycles each index is held before sampling; minimum 8, covering the digit engine's 4-phase multiply and decode pipeline.
REQ-004 Parameter MAX_INDEX, default 2^N-1: first index with no stored digit.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request a row fetch; sampled only when busy=0.
REQ-008 abort  in  1  cancel the fetch in progress.
REQ-009 base_index  in  N  index of the first digit of the row; sampled with accepted start.
REQ-010 busy  out  1  fetch in progress.
REQ-011 done  out  1  one-cycle pulse, coincident with the final wr_en of a completed row.
REQ-012 pi_index  out  N  index driven to the digit engine; registered.
REQ-013 pi_digit  in  4  digit returned by the digit engine.
REQ-014 wr_en  out  1  one-cycle row-buffer write strobe.
REQ-015 wr_addr  out  clog2(COLS) (min 1)  column being written.
REQ-016 wr_data  out  4  digit value written.

Function
REQ-017 States: IDLE, ISSUE; a fetch occupies ISSUE only; busy=1 exactly when state is ISSUE.
REQ-018 Control: settle counter sc; column counter col.
REQ-019 IDLE: start=1 and abort=0 -> ISSUE next cycle; loads pi_index<=base_index, sc<=0, col<=0.
REQ-020 start while busy=1 is ignored, with no effect on the fetch in progress.
REQ-021 ISSUE, pi_index<MAX_INDEX: sc increments each cycle; pi_index is held constant while sc<SETTLE-1.
REQ-022 At sc=SETTLE-1, in one edge: wr_data<=pi_digit, wr_addr<=col, wr_en<=1 (visible next cycle), pi_index<=pi_index+1, col<=col+1, sc<=0.
REQ-023 ISSUE, pi_index>=MAX_INDEX: the write is taken at sc=0 with wr_data<=4'hF, without waiting SETTLE; same counter and index updates as REQ-022.
REQ-024 pi_index increment wraps modulo 2^N; a wrapped index (< MAX_INDEX) resumes normal settle timing.
REQ-025 The write with col=COLS-1 returns to IDLE; done pulses with that wr_en, and busy=0 in that same cycle.
REQ-026 Latency, all indices valid: start accepted at edge 0 gives first wr_en in cycle SETTLE+1 and last wr_en/done in cycle COLS*SETTLE+1.
REQ-027 Consecutive wr_en pulses in one row are exactly SETTLE cycles apart, or 1 cycle apart for out-of-range indices.
REQ-028 wr_en and done are never high for more than one consecutive cycle.
REQ-029 abort=1 in ISSUE -> IDLE next edge; no further wr_en, no done.
REQ-030 A wr_en already registered on the abort edge still appears in the following cycle.
REQ-031 abort=1 with start=1 in IDLE: start is ignored.
REQ-032 start may be asserted in the cycle done pulses; it is accepted, and the next row begins the following cycle.
REQ-033 wr_data, wr_addr and pi_index hold their last values when idle.

Reset
REQ-034 rst_n=0 at any time, including mid-fetch, asynchronously forces:
- state=IDLE
- busy=0, done=0, wr_en=0
- wr_addr=0, wr_data=0, pi_index=0
- sc=0, col=0
REQ-035 After rst_n rises, no write occurs until a new start is accepted.

Verification
(Configuration for all scenarios: COLS=4, SETTLE=8, MAX_INDEX=100, engine model returning pi_digit=index mod 10 with 7-cycle latency.)
REQ-036 Start, base_index=10 -> wr_en in cycles 9, 17, 25, 33; data 0,1,2,3 at addr 0..3; done in cycle 33 only; busy high cycles 1..32.
REQ-037 Start, base_index=98 -> data 8,9 at cycles 9 and 17, then 4'hF at cycles 18 and 19; done in cycle 19.
REQ-038 Abort in cycle 12 after start at base 0 -> wr_en only in cycle 9; busy low from cycle 13; no done.
REQ-039 Start pulsed again in cycles 5 and 20 of an active fetch -> row unaffected, exactly 4 writes, one done.
REQ-040 rst_n low in cycle 14 mid-fetch -> all outputs 0 immediately; no wr_en afterwards without a new start.
REQ-041 Start asserted in the done cycle with base_index=50 -> second row's first wr_en 9 cycles later, data 0.
